// File: rtl/uart_cmd_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ==== uart_cmd_receiver : 8N1 UART deserializer + cipher/param/transmit command parser ====
// ==== Revision 1.0                                                                     ====
module uart_cmd_receiver #(
    parameter int CLKS_PER_BIT   = 434,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rx,
    output logic        cipher_w_en,
    output logic [2:0]  cipher_mem_sel,
    output logic [15:0] cipher_addr,
    output logic [7:0]  cipher_wdata,
    output logic        param_w_en,
    output logic [7:0]  param_addr,
    output logic [7:0]  param_wdata,
    output logic        start_encrypt,
    output logic        transmit_en,
    output logic [4:0]  transmit_sel,
    input  logic        transmit_done,
    output logic        busy,
    output logic        cmd_error
);

    localparam int               CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST    = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0]      TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PADDR, S_PDATA, S_TX_REQ, S_TX_WAIT} state_t;

    logic             rx_meta, rx_sync, rx_prev;
    rx_state_t        rx_state, rx_state_next;
    logic [CNT_W-1:0] bit_clk;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             byte_valid, frame_err;
    logic [7:0]       byte_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rx_state <= RX_IDLE;
        else       rx_state <= rx_state_next;
    end

    always_comb begin
        rx_state_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_sync) rx_state_next = RX_START;
            RX_START: if (bit_clk == HALF_LAST) rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_clk == BIT_LAST && bit_cnt == 3'd7) rx_state_next = RX_STOP;
            RX_STOP:  if (bit_clk == BIT_LAST) rx_state_next = RX_IDLE;
            default:  rx_state_next = RX_IDLE;
        endcase
    end

    // After the half-bit start check every sample lands mid-bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_clk    <= '0;
            bit_cnt    <= 3'd0;
            shift      <= 8'd0;
            byte_valid <= 1'b0;
            byte_data  <= 8'd0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    bit_clk <= '0;
                    bit_cnt <= 3'd0;
                end
                RX_START: begin
                    if (bit_clk == HALF_LAST) bit_clk <= '0;
                    else                      bit_clk <= bit_clk + 1'b1;
                end
                RX_DATA: begin
                    if (bit_clk == BIT_LAST) begin
                        bit_clk <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end else begin
                        bit_clk <= bit_clk + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (bit_clk == BIT_LAST) begin
                        bit_clk <= '0;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        bit_clk <= bit_clk + 1'b1;
                    end
                end
                default: bit_clk <= '0;
            endcase
        end
    end

    state_t      state, state_next;
    logic [2:0]  load_sel, load_sel_next;
    logic [3:0]  load_cnt, load_cnt_next;
    logic [31:0] timeout_cnt;
    logic        timed_state, timeout_hit;

    logic        cipher_w_en_next, param_w_en_next, start_encrypt_next;
    logic        transmit_en_next, cmd_error_next;
    logic [2:0]  cipher_mem_sel_next;
    logic [15:0] cipher_addr_next;
    logic [7:0]  cipher_wdata_next, param_addr_next, param_wdata_next;
    logic [4:0]  transmit_sel_next;

    assign timed_state = (state == S_LOAD) || (state == S_PADDR) || (state == S_PDATA);
    assign timeout_hit = timed_state && !byte_valid && (timeout_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                           timeout_cnt <= 32'd0;
        else if (timed_state && !byte_valid) timeout_cnt <= timeout_cnt + 32'd1;
        else                                 timeout_cnt <= 32'd0;
    end

    always_comb begin
        state_next          = state;
        load_sel_next       = load_sel;
        load_cnt_next       = load_cnt;
        cipher_w_en_next    = 1'b0;
        cipher_mem_sel_next = 3'b000;
        cipher_addr_next    = cipher_addr;
        cipher_wdata_next   = cipher_wdata;
        param_w_en_next     = 1'b0;
        param_addr_next     = param_addr;
        param_wdata_next    = param_wdata;
        start_encrypt_next  = 1'b0;
        transmit_en_next    = 1'b0;
        transmit_sel_next   = transmit_sel;
        cmd_error_next      = 1'b0;

        case (state)
            S_IDLE: begin
                if (byte_valid) begin
                    case (byte_data)
                        8'h01: begin
                            state_next    = S_LOAD;
                            load_sel_next = 3'b001;
                            load_cnt_next = 4'd0;
                        end
                        8'h02: begin
                            state_next    = S_LOAD;
                            load_sel_next = 3'b010;
                            load_cnt_next = 4'd0;
                        end
                        8'h10: state_next = S_PADDR;
                        8'h20: start_encrypt_next = 1'b1;
                        8'h30, 8'h31, 8'h32, 8'h33, 8'h34: begin
                            transmit_sel_next = 5'b00001 << byte_data[2:0];
                            transmit_en_next  = 1'b1;
                            state_next        = S_TX_REQ;
                        end
                        default: cmd_error_next = 1'b1;
                    endcase
                end
            end
            S_LOAD: begin
                if (byte_valid) begin
                    cipher_w_en_next    = 1'b1;
                    cipher_mem_sel_next = load_sel;
                    cipher_addr_next    = {12'd0, load_cnt};
                    cipher_wdata_next   = byte_data;
                    load_cnt_next       = load_cnt + 4'd1;
                    if (load_cnt == 4'd15) state_next = S_IDLE;
                end else if (timeout_hit) begin
                    cmd_error_next = 1'b1;
                    state_next     = S_IDLE;
                end
            end
            S_PADDR: begin
                if (byte_valid) begin
                    param_addr_next = byte_data;
                    state_next      = S_PDATA;
                end else if (timeout_hit) begin
                    cmd_error_next = 1'b1;
                    state_next     = S_IDLE;
                end
            end
            S_PDATA: begin
                if (byte_valid) begin
                    param_w_en_next  = 1'b1;
                    param_wdata_next = byte_data;
                    state_next       = S_IDLE;
                end else if (timeout_hit) begin
                    cmd_error_next = 1'b1;
                    state_next     = S_IDLE;
                end
            end
            // transmit_en is already on the wire during this single cycle.
            S_TX_REQ:  state_next = S_TX_WAIT;
            S_TX_WAIT: if (transmit_done) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase

        // A framing error never coincides with byte_valid, so it cannot clash with a write.
        if (frame_err) begin
            cmd_error_next = 1'b1;
            state_next     = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= S_IDLE;
            load_sel       <= 3'b000;
            load_cnt       <= 4'd0;
            cipher_w_en    <= 1'b0;
            cipher_mem_sel <= 3'b000;
            cipher_addr    <= 16'd0;
            cipher_wdata   <= 8'd0;
            param_w_en     <= 1'b0;
            param_addr     <= 8'd0;
            param_wdata    <= 8'd0;
            start_encrypt  <= 1'b0;
            transmit_en    <= 1'b0;
            transmit_sel   <= 5'd0;
            cmd_error      <= 1'b0;
        end else begin
            state          <= state_next;
            load_sel       <= load_sel_next;
            load_cnt       <= load_cnt_next;
            cipher_w_en    <= cipher_w_en_next;
            cipher_mem_sel <= cipher_mem_sel_next;
            cipher_addr    <= cipher_addr_next;
            cipher_wdata   <= cipher_wdata_next;
            param_w_en     <= param_w_en_next;
            param_addr     <= param_addr_next;
            param_wdata    <= param_wdata_next;
            start_encrypt  <= start_encrypt_next;
            transmit_en    <= transmit_en_next;
            transmit_sel   <= transmit_sel_next;
            cmd_error      <= cmd_error_next;
        end
    end

    // Busy covers the final write strobe so it drops the cycle after it.
    assign busy = (state != S_IDLE) || cipher_w_en || param_w_en;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ==== tb_uart_cmd_receiver : directed vectors and command sequences for uart_cmd_receiver ====
// ==== Revision 1.0                                                                        ====
module tb_uart_cmd_receiver;

    localparam int CPB = 16;
    localparam int TO  = 200;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rx = 1'b1;
    logic        transmit_done = 1'b0;
    logic        cipher_w_en, param_w_en, start_encrypt, transmit_en, busy, cmd_error;
    logic [2:0]  cipher_mem_sel;
    logic [15:0] cipher_addr;
    logic [7:0]  cipher_wdata, param_addr, param_wdata;
    logic [4:0]  transmit_sel;

    uart_cmd_receiver #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rstn(rstn), .rx(rx),
        .cipher_w_en(cipher_w_en), .cipher_mem_sel(cipher_mem_sel),
        .cipher_addr(cipher_addr), .cipher_wdata(cipher_wdata),
        .param_w_en(param_w_en), .param_addr(param_addr), .param_wdata(param_wdata),
        .start_encrypt(start_encrypt), .transmit_en(transmit_en),
        .transmit_sel(transmit_sel), .transmit_done(transmit_done),
        .busy(busy), .cmd_error(cmd_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]  wq_sel[$];
    logic [15:0] wq_addr[$];
    logic [7:0]  wq_data[$];
    logic [7:0]  pq_addr[$];
    logic [7:0]  pq_data[$];
    int          err_cnt = 0, start_cnt = 0, tx_cnt = 0, overlap_cnt = 0, selviol_cnt = 0;
    int          last_wr_cyc = 0, last_err_cyc = 0;
    logic [4:0]  tx_sel_seen = 5'd0;

    always @(negedge clk) begin
        if (rstn) begin
            if (cipher_w_en) begin
                wq_sel.push_back(cipher_mem_sel);
                wq_addr.push_back(cipher_addr);
                wq_data.push_back(cipher_wdata);
                last_wr_cyc <= cyc;
            end else if (cipher_mem_sel != 3'b000) begin
                selviol_cnt <= selviol_cnt + 1;
            end
            if (param_w_en) begin
                pq_addr.push_back(param_addr);
                pq_data.push_back(param_wdata);
            end
            if (start_encrypt) start_cnt <= start_cnt + 1;
            if (transmit_en) begin
                tx_cnt      <= tx_cnt + 1;
                tx_sel_seen <= transmit_sel;
            end
            if (cmd_error) begin
                err_cnt      <= err_cnt + 1;
                last_err_cyc <= cyc;
                if (cipher_w_en || param_w_en) overlap_cnt <= overlap_cnt + 1;
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_done();
        transmit_done = 1'b1;
        @(negedge clk);
        transmit_done = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        bit         stop;
        int         exp_err;
        int         exp_start;
        int         exp_tx;
        logic [4:0] exp_sel;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, s0, t0, w0, w1, p0, n, d;

        vecs[0] = '{8'h20, 1'b1, 0, 1, 0, 5'b00000};
        vecs[1] = '{8'h7E, 1'b1, 1, 0, 0, 5'b00000};
        vecs[2] = '{8'h00, 1'b1, 1, 0, 0, 5'b00000};
        vecs[3] = '{8'h35, 1'b1, 1, 0, 0, 5'b00000};
        vecs[4] = '{8'h2F, 1'b1, 1, 0, 0, 5'b00000};
        vecs[5] = '{8'h20, 1'b0, 1, 0, 0, 5'b00000};
        vecs[6] = '{8'h30, 1'b1, 0, 0, 1, 5'b00001};
        vecs[7] = '{8'h34, 1'b1, 0, 0, 1, 5'b10000};
        vecs[8] = '{8'hFF, 1'b0, 1, 0, 0, 5'b00000};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_ctrl", {22'd0, cipher_w_en, cipher_mem_sel, param_w_en, start_encrypt,
                             transmit_en, transmit_sel, cmd_error, busy}, 32'd0);
        check("reset_cipher", {8'd0, cipher_addr, cipher_wdata}, 32'd0);
        check("reset_param", {16'd0, param_addr, param_wdata}, 32'd0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Single-byte opcodes in IDLE
        for (int i = 0; i < NV; i++) begin
            e0 = err_cnt; s0 = start_cnt; t0 = tx_cnt;
            w0 = wq_sel.size(); p0 = pq_addr.size();
            send_byte(vecs[i].data, vecs[i].stop);
            repeat (8) @(negedge clk);
            check($sformatf("vec%0d_err", i), err_cnt - e0, vecs[i].exp_err);
            check($sformatf("vec%0d_start", i), start_cnt - s0, vecs[i].exp_start);
            check($sformatf("vec%0d_tx", i), tx_cnt - t0, vecs[i].exp_tx);
            check($sformatf("vec%0d_writes", i), (wq_sel.size() - w0) + (pq_addr.size() - p0), 0);
            check($sformatf("vec%0d_busy", i), {31'd0, busy}, (vecs[i].exp_tx != 0) ? 1 : 0);
            if (vecs[i].exp_tx != 0) begin
                check($sformatf("vec%0d_sel", i), {27'd0, tx_sel_seen}, {27'd0, vecs[i].exp_sel});
                pulse_done();
                repeat (3) @(negedge clk);
                check($sformatf("vec%0d_busy_end", i), {31'd0, busy}, 0);
            end
        end

        // Key load: 16 payload bytes
        w0 = wq_sel.size(); e0 = err_cnt;
        send_byte(8'h01, 1'b1);
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
        repeat (8) @(negedge clk);
        n = wq_sel.size() - w0;
        check("key_count", n, 16);
        for (int i = 0; i < 16 && i < n; i++)
            check($sformatf("key_wr%0d", i), {5'd0, wq_sel[w0+i], wq_addr[w0+i], wq_data[w0+i]},
                  {5'd0, 3'b001, 16'(i), 8'(i)});
        check("key_busy", {31'd0, busy}, 0);
        check("key_err", err_cnt - e0, 0);

        // Parameter write
        p0 = pq_addr.size();
        send_byte(8'h10, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'hA5, 1'b1);
        repeat (8) @(negedge clk);
        n = pq_addr.size() - p0;
        check("param_count", n, 1);
        if (n >= 1) check("param_wr", {16'd0, pq_addr[p0], pq_data[p0]}, 32'h0000_03A5);
        check("param_busy", {31'd0, busy}, 0);

        // Trace transmit request with a byte arriving during the wait
        t0 = tx_cnt; w0 = wq_sel.size(); e0 = err_cnt;
        send_byte(8'h33, 1'b1);
        repeat (4) @(negedge clk);
        check("tx_count", tx_cnt - t0, 1);
        check("tx_sel", {27'd0, tx_sel_seen}, 32'h08);
        check("tx_busy", {31'd0, busy}, 1);
        send_byte(8'h01, 1'b1);
        repeat (100) @(negedge clk);
        check("tx_wait_busy", {31'd0, busy}, 1);
        check("tx_wait_nowrite", wq_sel.size() - w0, 0);
        check("tx_sel_hold", {27'd0, transmit_sel}, 32'h08);
        pulse_done();
        repeat (3) @(negedge clk);
        check("tx_done_busy", {31'd0, busy}, 0);
        check("tx_err", err_cnt - e0, 0);

        // Plaintext load abandoned after 5 bytes
        w0 = wq_sel.size(); e0 = err_cnt;
        send_byte(8'h02, 1'b1);
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 1'b1);
        for (int k = 0; k < 400 && err_cnt == e0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("to_err", err_cnt - e0, 1);
        n = wq_sel.size() - w0;
        check("to_count", n, 5);
        for (int i = 0; i < 5 && i < n; i++)
            check($sformatf("to_wr%0d", i), {5'd0, wq_sel[w0+i], wq_addr[w0+i], wq_data[w0+i]},
                  {5'd0, 3'b010, 16'(i), 8'hA0 + 8'(i)});
        d = last_err_cyc - last_wr_cyc;
        check("to_latency", {31'd0, (d >= TO - 1) && (d <= TO + 1)}, 1);
        check("to_busy", {31'd0, busy}, 0);
        s0 = start_cnt;
        send_byte(8'h20, 1'b1);
        repeat (8) @(negedge clk);
        check("to_then_start", start_cnt - s0, 1);
        check("to_then_noerr", err_cnt - e0, 1);

        // Reset in the middle of a key load
        w0 = wq_sel.size();
        send_byte(8'h01, 1'b1);
        for (int i = 0; i < 8; i++) send_byte(8'hC0 + 8'(i), 1'b1);
        check("rst_pre_count", wq_sel.size() - w0, 8);
        rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rst_ctrl", {22'd0, cipher_w_en, cipher_mem_sel, param_w_en, start_encrypt,
                           transmit_en, transmit_sel, cmd_error, busy}, 32'd0);
        check("rst_cipher", {8'd0, cipher_addr, cipher_wdata}, 32'd0);
        check("rst_param", {16'd0, param_addr, param_wdata}, 32'd0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        w1 = wq_sel.size();
        send_byte(8'h02, 1'b1);
        for (int i = 0; i < 16; i++) send_byte(8'h50 + 8'(i), 1'b1);
        repeat (8) @(negedge clk);
        n = wq_sel.size() - w1;
        check("rst_reload_count", n, 16);
        for (int i = 0; i < 16 && i < n; i++)
            check($sformatf("rst_wr%0d", i), {5'd0, wq_sel[w1+i], wq_addr[w1+i], wq_data[w1+i]},
                  {5'd0, 3'b010, 16'(i), 8'h50 + 8'(i)});
        check("rst_reload_busy", {31'd0, busy}, 0);

        check("err_write_overlap", overlap_cnt, 0);
        check("mem_sel_idle_zero", selviol_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_cmd_receiver.md
# uart_cmd_receiver

Receive-side counterpart of the trace/cipher sender: deserializes 8N1 UART bytes from the PC and decodes a byte-oriented command protocol. Commands load the key and plaintext cipher memories, write parameter registers, trigger an encryption run, and issue transmit requests (`transmit_en`/`transmit_sel`) to the sender. The block then waits for the sender's `transmit_done`.

## Interface
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); minimum 4
- TIMEOUT_CYCLES, 1_000_000, maximum idle gap between payload bytes before a command is aborted; 32-bit counter
- clk  input  1  system clock
- rstn  input  1  reset; one clock, reset is asynchronous and active-low
- rx  input  1  UART serial line, idle high, asynchronous to clk
- cipher_w_en  output  1  one-cycle write strobe to cipher memory
- cipher_mem_sel  output  3  001 key, 010 plaintext; 000 when not writing
- cipher_addr  output  16  write address, 0..15
- cipher_wdata  output  8  write byte
- param_w_en  output  1  one-cycle parameter write strobe
- param_addr  output  8  parameter address
- param_wdata  output  8  parameter byte
- start_encrypt  output  1  one-cycle pulse that starts an encryption run
- transmit_en  output  1  one-cycle request to the sender
- transmit_sel  output  5  one-hot select: 00001 key, 00010 pt, 00100 ct, 01000 trace, 10000 param
- transmit_done  input  1  sender completion pulse
- busy  output  1  high whenever the parser is not in IDLE
- cmd_error  output  1  one-cycle pulse on an unknown opcode, framing error, or timeout

## Operation
- UART RX: rx goes through a 2-flop synchronizer. A falling edge arms reception, and the start bit is re-checked at CLKS_PER_BIT/2.
  - If the line is high at that check, reception aborts silently.
  - Data bits are sampled mid-bit, LSB first, then the stop bit.
  - Stop bit = 1: `byte_valid` pulses for one cycle with the byte.
  - Stop bit = 0: the byte is dropped, cmd_error pulses, and the parser returns to IDLE.
- Parser states: IDLE, LOAD, PADDR, PDATA, TX_REQ, TX_WAIT.
- Opcodes, accepted in IDLE only:
  - 0x01: enter LOAD with mem_sel 001 and addr 0.
  - 0x02: enter LOAD with mem_sel 010 and addr 0.
  - 0x10: enter PADDR.
  - 0x20: pulse start_encrypt and stay in IDLE.
  - 0x30+n, n = 0..4: latch transmit_sel = 1<<n and go to TX_REQ.
  - Any other value: pulse cmd_error and stay in IDLE.
- LOAD: each received byte causes one write, with cipher_w_en=1, addr = count, data = byte; then the count increments. After the write at addr 15 the parser returns to IDLE. Exactly 16 payload bytes are consumed.
- PADDR: the received byte is latched as param_addr, then go to PDATA. PDATA: the received byte produces param_w_en with param_wdata = byte, then return to IDLE.
- TX_REQ: pulse transmit_en for one cycle with transmit_sel valid, then go to TX_WAIT.
- TX_WAIT: stay until transmit_done=1, then go to IDLE.
  - Bytes received in TX_WAIT are discarded without error.
  - transmit_sel holds its value until the next transmit opcode.
- Timeout: the counter runs only in LOAD, PADDR and PDATA, and clears on every byte_valid. On reaching TIMEOUT_CYCLES: pulse cmd_error and go to IDLE. Loaded addresses already written stay written.
- Reset mid-command: all state clears; the partial command is lost, and a partially received byte is lost.

## Timing
- Reset values:
  - All outputs 0, except cipher_addr = 0, param_addr = 0 and transmit_sel = 0.
  - Internal rx synchronizer resets to 1 (idle).
- byte_valid rises 2 + 9.5·CLKS_PER_BIT (±1) cycles after the rx start-bit falling edge.
- Write strobe, start_encrypt and transmit_en are registered: they assert on the cycle after byte_valid.
  - Address, data and mem_sel are valid in the same cycle as the strobe.
  - cipher_mem_sel returns to 000 on the following cycle.
- TX_REQ lasts exactly one cycle. transmit_done is sampled starting the cycle after transmit_en.
- busy rises on the cycle after the opcode's byte_valid. It falls on the cycle after the final write, or after the transmit_done sample.
- cmd_error and a write never occur in the same cycle.

## Test plan
- Send 0x01 followed by bytes 0x00..0x0F → 16 cipher_w_en pulses with mem_sel 001, addr 0..15 and wdata equal to addr; busy low afterwards; no cmd_error.
- Send 0x10, 0x03, 0xA5 → one param_w_en with param_addr 0x03 and param_wdata 0xA5.
- Send 0x33 with the bench holding transmit_done low for 100 cycles, then pulsing it → one transmit_en with transmit_sel 01000. busy stays high until the pulse, and a 0x01 byte sent during the wait produces no write.
- Send 0x02 plus 5 bytes, then go idle with TIMEOUT_CYCLES=200 → 5 writes (addr 0..4), then cmd_error after 200 cycles, then IDLE. A following 0x20 yields start_encrypt.
- Send 0x7E; separately send a byte with stop bit 0 → cmd_error pulse for each, no other strobes.
- Assert rstn low midway through the 0x01 payload at byte 8 → all outputs 0 immediately. A new 0x02 plus 16 bytes then writes addr 0..15 with mem_sel 010.
